// File: rtl/rot_btn_conditioner_pkg.sv
// tetris_input_pkg: shared types, timing defaults and sizing helpers for the
// Tetris push-button front ends (rotate, left, right, drop).
// No ports; imported with `import tetris_input_pkg::*;`.
package tetris_input_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } btn_state_t;

    // Timings at a 100 MHz system clock.
    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 500000;    // 5 ms
    localparam int unsigned DEFAULT_REPEAT_DELAY    = 40000000;  // 400 ms
    localparam int unsigned DEFAULT_REPEAT_PERIOD   = 15000000;  // 150 ms

    // Bits needed to hold values 0..max_val (never less than 1).
    function automatic int unsigned cnt_width(input int unsigned max_val);
        if (max_val < 1) begin
            return 1;
        end
        return int'($clog2(max_val + 1));
    endfunction

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rot_btn_conditioner_if.sv
// rot_btn_conditioner_if: button-side and rotatefsm-side signals of the
// rotate button conditioner.
//   btn_raw   : raw asynchronous button level, 1 = pressed
//   enable    : game-active gate for rot pulses
//   rot       : one-cycle rotate request
//   btn_level : debounced button level
// modport master: the environment (drives btn_raw/enable, observes outputs)
// modport slave : the conditioner itself
interface rot_btn_conditioner_if;

    logic btn_raw;
    logic enable;
    logic rot;
    logic btn_level;

    modport master (
        output btn_raw,
        output enable,
        input  rot,
        input  btn_level
    );

    modport slave (
        input  btn_raw,
        input  enable,
        output rot,
        output btn_level
    );

endinterface

// File: rtl/rot_btn_conditioner_sync_2ff.sv
// sync_2ff: generic two-flop synchronizer for asynchronous level inputs.
// Synchronous active-low reset clears both stages to 0.
// Ports:
//   clock : system clock (rising edge)
//   reset : synchronous reset, 0 = reset
//   d     : asynchronous input
//   q     : synchronized output, two clock edges behind d
module sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clock) begin
        if (!reset) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/rot_btn_conditioner.sv
// rot_btn_conditioner: rotate-button front end. Synchronizes the raw button,
// debounces press and release with a 4-state FSM and issues one registered
// `rot` pulse per qualified press (gated by enable on the qualifying edge).
// Optional auto-repeat while held: define ROT_AUTOREPEAT_EN.
// Ports:
//   clock : system clock (rising edge)
//   reset : synchronous reset, 0 = reset
//   bus   : rot_btn_conditioner_if.slave (btn_raw, enable in; rot, btn_level out)
module rot_btn_conditioner
    import tetris_input_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned REPEAT_DELAY    = DEFAULT_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD   = DEFAULT_REPEAT_PERIOD
) (
    input  logic                   clock,
    input  logic                   reset,
    rot_btn_conditioner_if.slave   bus
);

    localparam int unsigned         CNT_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s;
    btn_state_t       state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             qual_pulse;
    logic             rot_next;
    logic             level_next;

    sync_2ff #(.WIDTH(1)) u_sync (
        .clock (clock),
        .reset (reset),
        .d     (bus.btn_raw),
        .q     (s)
    );

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        qual_pulse = 1'b0;
        case (state)
            IDLE: begin
                if (s) begin
                    state_next = PRESS_WAIT;
                    cnt_next   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!s) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_next = HELD;
                    qual_pulse = bus.enable;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            HELD: begin
                if (!s) begin
                    state_next = RELEASE_WAIT;
                    cnt_next   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (s) begin
                    state_next = HELD;
                    cnt_next   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
        // btn_level is registered from the next state so it rises with rot.
        level_next = (state_next == HELD) || (state_next == RELEASE_WAIT);
    end

`ifdef ROT_AUTOREPEAT_EN
    localparam int unsigned          RCNT_W      = cnt_width(max_u(REPEAT_DELAY, REPEAT_PERIOD));
    localparam logic [RCNT_W-1:0]    DELAY_LAST  = RCNT_W'(REPEAT_DELAY - 1);
    localparam logic [RCNT_W-1:0]    PERIOD_LAST = RCNT_W'(REPEAT_PERIOD - 1);

    // rphase=0: waiting out the initial delay; 1: in the periodic phase.
    logic [RCNT_W-1:0] rcnt, rcnt_next;
    logic              rphase, rphase_next;
    logic              rep_fire;

    always_comb begin
        rcnt_next   = rcnt;
        rphase_next = rphase;
        rep_fire    = 1'b0;
        if (state_next == HELD && state != HELD) begin
            rcnt_next   = '0;
            rphase_next = 1'b0;
        end else if (state == HELD) begin
            if (rphase ? (rcnt == PERIOD_LAST) : (rcnt == DELAY_LAST)) begin
                rep_fire    = 1'b1;
                rcnt_next   = '0;
                rphase_next = 1'b1;
            end else begin
                rcnt_next = rcnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            rcnt   <= '0;
            rphase <= 1'b0;
        end else begin
            rcnt   <= rcnt_next;
            rphase <= rphase_next;
        end
    end

    assign rot_next = qual_pulse | (rep_fire & bus.enable);
`else
    logic unused_repeat_cfg;
    assign unused_repeat_cfg = ^{32'(REPEAT_DELAY), 32'(REPEAT_PERIOD)};
    assign rot_next          = qual_pulse;
`endif

    always_ff @(posedge clock) begin
        if (!reset) begin
            state         <= IDLE;
            cnt           <= '0;
            bus.rot       <= 1'b0;
            bus.btn_level <= 1'b0;
        end else begin
            state         <= state_next;
            cnt           <= cnt_next;
            bus.rot       <= rot_next;
            bus.btn_level <= level_next;
        end
    end

endmodule

// File: tb/tb_rot_btn_conditioner.sv
// tb_rot_btn_conditioner: randomized bench for rot_btn_conditioner with a
// behavioural reference model (stable-run debouncing, press/hold counting).
module tb_rot_btn_conditioner;

    localparam int unsigned DEB  = 4;
    localparam int unsigned RDLY = 8;
    localparam int unsigned RPER = 3;

    logic clock = 1'b0;
    logic reset = 1'b0;

    rot_btn_conditioner_if bus();

    rot_btn_conditioner #(
        .DEBOUNCE_CYCLES (DEB),
        .REPEAT_DELAY    (RDLY),
        .REPEAT_PERIOD   (RPER)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model. The button as seen by the debouncer is the raw level
    // two edges late. The debounced level toggles once the seen level has
    // disagreed with it on DEB+1 consecutive edges; any agreeing edge resets
    // the run. "Held" means level high with no disagreement pending.
    bit          raw_1ago, raw_2ago;
    bit          m_level;
    int unsigned m_run;
    int unsigned m_held_edges;
    bit          exp_rot, exp_level;

    task automatic model_edge();
        bit seen, fire, was_held;
        if (!reset) begin
            raw_1ago = 0; raw_2ago = 0;
            m_level = 0; m_run = 0; m_held_edges = 0;
            exp_rot = 0; exp_level = 0;
            return;
        end
        seen     = raw_2ago;
        raw_2ago = raw_1ago;
        raw_1ago = bus.btn_raw;
        fire     = 0;
        was_held = m_level && (m_run == 0);
`ifdef ROT_AUTOREPEAT_EN
        if (was_held) begin
            m_held_edges++;
            if (m_held_edges == RDLY ||
                (m_held_edges > RDLY && (m_held_edges - RDLY) % RPER == 0))
                fire = 1;
        end
`endif
        if (seen != m_level) begin
            m_run++;
            if (m_run == DEB + 1) begin
                m_level = !m_level;
                m_run   = 0;
                if (m_level) fire = 1;
            end
        end else begin
            m_run = 0;
        end
        if (m_level && m_run == 0 && !was_held) m_held_edges = 0;
        exp_rot   = fire && bus.enable;
        exp_level = m_level;
    endtask

    task automatic step();
        @(posedge clock);
        model_edge();
        #1;
        check("rot", bus.rot, exp_rot);
        check("btn_level", bus.btn_level, exp_level);
    endtask

    task automatic hold_raw(input bit v, input int unsigned n);
        bus.btn_raw = v;
        for (int unsigned i = 0; i < n; i++) begin
            if ($urandom_range(0, 15) == 0) bus.enable = ~bus.enable;
            step();
        end
    endtask

    initial begin
        int unsigned lat;
        bus.btn_raw = 0;
        bus.enable  = 0;
        reset       = 0;
        repeat (3) step();
        reset = 1;
        bus.enable = 1;
        repeat (5) step();

        // Clean press: first rot expected DEB+2 edges after the first high sample.
        bus.btn_raw = 1;
        lat = 0;
        for (int unsigned i = 1; i <= 30; i++) begin
            step();
            if (bus.rot === 1'b1) begin
                lat = i - 1;
                break;
            end
        end
        check("press_latency", lat, DEB + 2);
        repeat (20) step();
        bus.btn_raw = 0;
        repeat (15) step();

        // Bounce rejection: short pulses never qualify.
        for (int unsigned r = 0; r < 3; r++) begin
            hold_raw(1, 2);
            hold_raw(0, 3);
        end
        check("bounce_level", bus.btn_level, 0);

        // Randomized segments.
        for (int unsigned seg = 0; seg < 400; seg++) begin
            case ($urandom_range(0, 5))
                0: hold_raw(1, $urandom_range(5, 40));
                1: hold_raw(0, $urandom_range(5, 30));
                2: begin
                    for (int unsigned b = $urandom_range(1, 4); b > 0; b--) begin
                        hold_raw(1, $urandom_range(1, 3));
                        hold_raw(0, $urandom_range(1, 3));
                    end
                end
                3: begin
                    reset = 0;
                    bus.btn_raw = $urandom_range(0, 1);
                    repeat ($urandom_range(1, 2)) step();
                    reset = 1;
                end
                default: begin
                    for (int unsigned c = $urandom_range(3, 12); c > 0; c--) begin
                        bus.btn_raw = $urandom_range(0, 1);
                        step();
                    end
                end
            endcase
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rot_btn_conditioner.md
Name: rot_btn_conditioner

Overview:
Front end for the rotate button: takes the raw, asynchronous, bouncing push-button and produces the one-cycle `rot` request pulse consumed by rotatefsm.
- Synchronizes the input, debounces press and release with a 4-state FSM, and emits exactly one pulse per qualified press.
- Optionally emits auto-repeat pulses while the button is held.
- Sits between the board button pin and the rotatefsm `rot` input.

Parameters:
DEBOUNCE_CYCLES, 500000, stable cycles needed to qualify a press or release (5 ms at 100 MHz); legal range >= 1.
REPEAT_DELAY, 40000000, cycles held in HELD before the first auto-repeat pulse (optional feature only); >= 1.
REPEAT_PERIOD, 15000000, cycles between later auto-repeat pulses (optional feature only); >= 1.

Ports:
clock  in  1  system clock; all logic is rising-edge.
reset  in  1  synchronous, active-low reset; 0 = reset.
btn_raw  in  1  raw asynchronous button level; 1 = pressed.
enable  in  1  game-active gate; when 0, `rot` pulses are suppressed, but the FSM still tracks the button.
rot  out  1  one-cycle rotate request to rotatefsm; registered.
btn_level  out  1  debounced button level; registered.

Behaviour:
- Reset (reset==0 at an edge):
  - both sync flops, state, and all counters go to 0; state becomes IDLE.
  - rot=0, btn_level=0.
  - Reset overrides everything, including mid-debounce and mid-repeat.
- Synchronizer: 2-flop chain (s1<=btn_raw, s<=s1). The FSM only ever sees `s`.
- States: IDLE, PRESS_WAIT, HELD, RELEASE_WAIT. Debounce counter `cnt` has width clog2(DEBOUNCE_CYCLES+1).
- IDLE: if s==1, go to PRESS_WAIT with cnt=0.
- PRESS_WAIT:
  - s==0: go to IDLE with cnt=0 (bounce rejected, no pulse).
  - s==1 and cnt==DEBOUNCE_CYCLES-1: go to HELD and set rot<=enable.
  - otherwise: cnt<=cnt+1.
- HELD: if s==0, go to RELEASE_WAIT with cnt=0.
- RELEASE_WAIT:
  - s==1: return to HELD with cnt=0, no pulse.
  - s==0 and cnt==DEBOUNCE_CYCLES-1: go to IDLE.
  - otherwise: cnt++.
- rot:
  - high for exactly one cycle per qualified press; 0 in every other cycle.
  - Never two consecutive high cycles (except as noted for the optional feature).
- btn_level: registered, equals 1 exactly while state is HELD or RELEASE_WAIT.
- Latency: with the first edge that samples btn_raw=1 called edge k, and btn_raw stable high from then on, rot rises on edge k+DEBOUNCE_CYCLES+2.
- enable: sampled only on the qualifying edge. If enable is low there, no pulse is produced and none is deferred; a later rise of enable while still held produces nothing.
- Button held across reset release: treated as a fresh press, qualified normally, and yields one pulse.

Optional Feature:
Macro: ROT_AUTOREPEAT_EN.
- Defined:
  - A repeat counter `rcnt` (width clog2(max(REPEAT_DELAY,REPEAT_PERIOD)+1)) is cleared on every entry to HELD, including the return from RELEASE_WAIT.
  - rcnt counts every cycle in HELD and holds its value in RELEASE_WAIT.
  - On reaching REPEAT_DELAY-1, the block emits rot<=enable and reloads rcnt for the period.
  - Thereafter it emits a pulse each time REPEAT_PERIOD cycles elapse.
  - With REPEAT_PERIOD==1, rot may be high on consecutive cycles.
- Not defined: REPEAT_* parameters are accepted but unused; rcnt is not synthesized; exactly one pulse per press.

Decomposition:
- Package tetris_input_pkg:
  - state typedef (2-bit enum IDLE=0, PRESS_WAIT=1, HELD=2, RELEASE_WAIT=3).
  - counter-width helper function.
  - default timing constants.
- Sub-module sync_2ff: generic 2-flop synchronizer with synchronous active-low reset to 0. It will be reused by the other Tetris buttons (left/right/drop).

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4, REPEAT_DELAY=8, REPEAT_PERIOD=3, 10 ns clock.
1. Clean press: enable=1, btn_raw rises and is sampled at edge k, held 20 cycles -> rot high for exactly one cycle, rising at edge k+6; btn_level rises at the same edge; no further pulses.
2. Bounce rejection: btn_raw pulses high for 2 cycles then low, three times -> no rot pulse, btn_level stays 0, state returns to IDLE.
3. Release bounce: while held, drop btn_raw for 2 cycles then restore -> btn_level stays 1, no second pulse. Then a clean release -> btn_level falls 6 edges after the first low sample.
4. Enable gating: press with enable=0 -> no pulse; raise enable while still held -> no pulse; release and press again with enable=1 -> exactly one pulse.
5. Reset mid-press: assert reset=0 for 2 cycles during PRESS_WAIT with btn_raw held high -> rot=0 and btn_level=0 during reset; after release exactly one pulse, at 6 edges after the first post-reset sample.
6. ROT_AUTOREPEAT_EN: hold for 30 cycles after qualification -> pulses at qualification, then +8, +11, +14, ...; without the macro -> a single pulse.
